// File: rtl/ahb_lite_protocol_checker.sv
// rtl/ahb_lite_protocol_checker.sv - passive AHB-Lite address-phase protocol checker
//
// Purpose: watches an AHB-Lite address phase and flags HTRANS/HBURST misuse,
// wrong SEQ addresses, unstable wait states and oversized HSIZE. Each offending
// cycle produces a registered one-cycle err_valid pulse carrying the lowest
// error code and the offending HADDR. Errors and accepted transfers are counted
// with saturating counters.
//
// Ports:
//   HCLK, HRESETn          clock, synchronous active-low reset
//   HADDR/HTRANS/HWRITE    address-phase controls from the master
//   HSIZE/HBURST/HREADY
//   err_valid/code/addr    registered error report (code/addr hold until next error)
//   err_count, xfer_count  saturating error / accepted NONSEQ+SEQ counters
//   burst_active           FSM is in BURST
//
// Optional macro AHB_CHK_ASSERT_EN: also prints a simulation $error per error.
module ahb_lite_protocol_checker #(
    parameter int ADDR_W = 21,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [2:0]        HBURST,
    input  logic              HREADY,
    output logic              err_valid,
    output logic [2:0]        err_code,
    output logic [ADDR_W-1:0] err_addr,
    output logic [CNT_W-1:0]  err_count,
    output logic [CNT_W-1:0]  xfer_count,
    output logic              burst_active
);
    localparam logic [1:0]       T_IDLE   = 2'b00;
    localparam logic [1:0]       T_BUSY   = 2'b01;
    localparam logic [1:0]       T_NONSEQ = 2'b10;
    localparam logic [1:0]       T_SEQ    = 2'b11;
    localparam logic [2:0]       B_SINGLE = 3'd0;
    localparam logic [2:0]       B_INCR   = 3'd1;
    localparam logic [2:0]       MAX_SIZE = 3'($clog2(DATA_W / 8));
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic {S_IDLE, S_BURST} state_t;

    state_t            state_q, state_d;
    logic [3:0]        beats_q, beats_d;
    logic              fixed_q, fixed_d;
    logic [2:0]        size_q, size_d;
    logic [2:0]        burst_q, burst_d;
    logic [ADDR_W-1:0] exp_q, exp_d;

    // Previous-cycle snapshot used for wait-state stability.
    logic              wait_q;
    logic [ADDR_W-1:0] p_addr_q;
    logic [1:0]        p_trans_q;
    logic              p_write_q;
    logic [2:0]        p_size_q, p_burst_q;

    logic              err_valid_q;
    logic [2:0]        err_code_q, code_d;
    logic [ADDR_W-1:0] err_addr_q;
    logic [CNT_W-1:0]  err_cnt_q, xfer_cnt_q;

    logic e1, e2, e3, e4, e5, e6, any_err, active;

    // Wrapping bursts keep the upper address bits and wrap the low bits
    // within an n*bytes window; everything else simply increments.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                    input logic [2:0] size,
                                                    input logic [2:0] burst);
        logic [ADDR_W-1:0] bytes, bound, mask;
        bytes = {{(ADDR_W-1){1'b0}}, 1'b1} << size;
        case (burst)
            3'd2:    bound = bytes << 2;
            3'd4:    bound = bytes << 3;
            3'd6:    bound = bytes << 4;
            default: bound = '0;
        endcase
        mask = bound - {{(ADDR_W-1){1'b0}}, 1'b1};
        if (bound != '0) begin
            next_addr = (a & ~mask) | ((a + bytes) & mask);
        end else begin
            next_addr = a + bytes;
        end
    endfunction

    always_comb begin
        state_d = state_q;
        beats_d = beats_q;
        fixed_d = fixed_q;
        size_d  = size_q;
        burst_d = burst_q;
        exp_d   = exp_q;
        active  = HTRANS[1];

        e1 = HREADY && (HTRANS == T_BUSY) && (state_q == S_IDLE);
        e2 = HREADY && (HTRANS == T_SEQ) && (state_q == S_IDLE);
        e3 = HREADY && (HTRANS == T_SEQ) && (state_q == S_BURST) &&
             ((HADDR != exp_q) || (HSIZE != size_q) || (HBURST != burst_q));
        e4 = wait_q &&
             ((HADDR != p_addr_q) || (HTRANS != p_trans_q) || (HWRITE != p_write_q) ||
              (HSIZE != p_size_q) || (HBURST != p_burst_q)) &&
             !((p_trans_q == T_IDLE) && (HTRANS == T_NONSEQ));
        e5 = HREADY && active && (HSIZE > MAX_SIZE);
        e6 = HREADY && ((HTRANS == T_NONSEQ) || (HTRANS == T_IDLE)) &&
             (state_q == S_BURST) && fixed_q && (beats_q != 4'd0);
        any_err = e1 | e2 | e3 | e4 | e5 | e6;

        // Later assignments win, so the lowest active code is reported.
        code_d = 3'd0;
        if (e6) code_d = 3'd6;
        if (e5) code_d = 3'd5;
        if (e4) code_d = 3'd4;
        if (e3) code_d = 3'd3;
        if (e2) code_d = 3'd2;
        if (e1) code_d = 3'd1;

        if (HREADY && active) begin
            exp_d = next_addr(HADDR, HSIZE, HBURST);
        end

        if (HREADY) begin
            case (HTRANS)
                T_NONSEQ: begin
                    if (HBURST != B_SINGLE) begin
                        state_d = S_BURST;
                        size_d  = HSIZE;
                        burst_d = HBURST;
                        fixed_d = (HBURST != B_INCR);
                        case (HBURST[2:1])
                            2'b01:   beats_d = 4'd3;
                            2'b10:   beats_d = 4'd7;
                            2'b11:   beats_d = 4'd15;
                            default: beats_d = 4'd0;
                        endcase
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                T_SEQ: begin
                    if ((state_q == S_BURST) && fixed_q) begin
                        beats_d = beats_q - 4'd1;
                        if (beats_q == 4'd1) state_d = S_IDLE;
                    end
                end
                T_IDLE:  state_d = S_IDLE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q     <= S_IDLE;
            beats_q     <= '0;
            fixed_q     <= 1'b0;
            size_q      <= '0;
            burst_q     <= '0;
            exp_q       <= '0;
            wait_q      <= 1'b0;
            p_addr_q    <= '0;
            p_trans_q   <= '0;
            p_write_q   <= 1'b0;
            p_size_q    <= '0;
            p_burst_q   <= '0;
            err_valid_q <= 1'b0;
            err_code_q  <= '0;
            err_addr_q  <= '0;
            err_cnt_q   <= '0;
            xfer_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            beats_q     <= beats_d;
            fixed_q     <= fixed_d;
            size_q      <= size_d;
            burst_q     <= burst_d;
            exp_q       <= exp_d;
            wait_q      <= !HREADY && active;
            p_addr_q    <= HADDR;
            p_trans_q   <= HTRANS;
            p_write_q   <= HWRITE;
            p_size_q    <= HSIZE;
            p_burst_q   <= HBURST;
            err_valid_q <= any_err;
            if (any_err) begin
                err_code_q <= code_d;
                err_addr_q <= HADDR;
                if (err_cnt_q != CNT_MAX) err_cnt_q <= err_cnt_q + CNT_W'(1);
            end
            if (HREADY && active && (xfer_cnt_q != CNT_MAX)) begin
                xfer_cnt_q <= xfer_cnt_q + CNT_W'(1);
            end
        end
    end

`ifdef AHB_CHK_ASSERT_EN
    function automatic string code_name(input logic [2:0] c);
        case (c)
            3'd1:    code_name = "BUSY_NO_BURST";
            3'd2:    code_name = "SEQ_NO_BURST";
            3'd3:    code_name = "SEQ_ADDR";
            3'd4:    code_name = "WAIT_UNSTABLE";
            3'd5:    code_name = "BAD_SIZE";
            3'd6:    code_name = "EARLY_TERM";
            default: code_name = "NONE";
        endcase
    endfunction

    // Fires on the same edge that raises err_valid.
    always_ff @(posedge HCLK) begin
        if (HRESETn && any_err) begin
            $error("ahb_chk %s HADDR=%0h HTRANS=%0b", code_name(code_d), HADDR, HTRANS);
        end
    end
`else
    // Silent build: errors are visible only on the output ports.
`endif

    assign err_valid    = err_valid_q;
    assign err_code     = err_code_q;
    assign err_addr     = err_addr_q;
    assign err_count    = err_cnt_q;
    assign xfer_count   = xfer_cnt_q;
    assign burst_active = (state_q == S_BURST);
endmodule

// File: tb/tb_ahb_lite_protocol_checker.sv
// tb/tb_ahb_lite_protocol_checker.sv - self-checking bench for ahb_lite_protocol_checker
module tb_ahb_lite_protocol_checker;
    localparam int AW    = 21;
    localparam int AMASK = (1 << AW) - 1;

    logic          HCLK = 1'b0;
    logic          HRESETn = 1'b0;
    logic [AW-1:0] HADDR = '0;
    logic [1:0]    HTRANS = 2'b00;
    logic          HWRITE = 1'b0;
    logic [2:0]    HSIZE = 3'd0;
    logic [2:0]    HBURST = 3'd0;
    logic          HREADY = 1'b1;

    logic          err_valid, burst_active;
    logic [2:0]    err_code;
    logic [AW-1:0] err_addr;
    logic [15:0]   err_count, xfer_count;

    logic          s_err_valid, s_burst_active;
    logic [2:0]    s_err_code;
    logic [AW-1:0] s_err_addr;
    logic [1:0]    s_err_count, s_xfer_count;

    always #5 HCLK = ~HCLK;

    ahb_lite_protocol_checker #(.ADDR_W(AW), .DATA_W(8), .CNT_W(16)) u_dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HREADY(HREADY),
        .err_valid(err_valid), .err_code(err_code), .err_addr(err_addr),
        .err_count(err_count), .xfer_count(xfer_count), .burst_active(burst_active)
    );

    ahb_lite_protocol_checker #(.ADDR_W(AW), .DATA_W(8), .CNT_W(2)) u_small (
        .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HREADY(HREADY),
        .err_valid(s_err_valid), .err_code(s_err_code), .err_addr(s_err_addr),
        .err_count(s_err_count), .xfer_count(s_xfer_count), .burst_active(s_burst_active)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: remaining = -1 means an unbounded INCR burst.
    bit m_in_burst;
    int m_remaining, m_size, m_btype, m_exp;
    bit m_wait;
    int p_addr, p_trans, p_write, p_size, p_burst;
    int m_errcnt, m_xfer, m_code, m_eaddr;
    bit m_ev;
    int beats_tab[8] = '{0, -1, 3, 3, 7, 7, 15, 15};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int next_exp(input int addr, input int size, input int burst);
        int bytes, bound, off;
        bytes = 1 << size;
        if (burst == 2 || burst == 4 || burst == 6) begin
            bound = bytes * ((burst == 2) ? 4 : (burst == 4) ? 8 : 16);
            off   = addr % bound;
            return addr - off + ((off + bytes) % bound);
        end
        return (addr + bytes) & AMASK;
    endfunction

    function automatic int sat3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    task automatic model_reset();
        m_in_burst = 0; m_remaining = 0; m_size = 0; m_btype = 0; m_exp = 0;
        m_wait = 0; p_addr = 0; p_trans = 0; p_write = 0; p_size = 0; p_burst = 0;
        m_errcnt = 0; m_xfer = 0; m_code = 0; m_eaddr = 0; m_ev = 0;
    endtask

    task automatic model_step(input int t, input int a, input int w, input int s,
                              input int b, input int r);
        int c;
        c = 7;
        if (r != 0) begin
            if (t == 1 && !m_in_burst && c > 1) c = 1;
            if (t == 3 && !m_in_burst && c > 2) c = 2;
            if (t == 3 && m_in_burst && (a != m_exp || s != m_size || b != m_btype) && c > 3) c = 3;
            if (t >= 2 && s > 0 && c > 5) c = 5;
            if ((t == 2 || t == 0) && m_in_burst && m_remaining > 0 && c > 6) c = 6;
        end
        if (m_wait && (a != p_addr || t != p_trans || w != p_write || s != p_size || b != p_burst)
            && !(p_trans == 0 && t == 2) && c > 4) c = 4;

        m_ev = (c < 7);
        if (m_ev) begin
            m_code = c; m_eaddr = a; m_errcnt++;
        end
        if (r != 0 && t >= 2) begin
            m_xfer++;
            m_exp = next_exp(a, s, b);
        end
        if (r != 0) begin
            if (t == 2) begin
                if (b != 0) begin
                    m_in_burst = 1; m_size = s; m_btype = b; m_remaining = beats_tab[b];
                end else begin
                    m_in_burst = 0;
                end
            end else if (t == 3) begin
                if (m_in_burst && m_remaining > 0) begin
                    m_remaining--;
                    if (m_remaining == 0) m_in_burst = 0;
                end
            end else if (t == 0) begin
                m_in_burst = 0;
            end
        end
        m_wait = (r == 0) && (t >= 2);
        p_addr = a; p_trans = t; p_write = w; p_size = s; p_burst = b;
    endtask

    task automatic compare_all();
        check("err_valid", err_valid, m_ev);
        check("err_code", err_code, m_code);
        check("err_addr", err_addr, m_eaddr);
        check("err_count", err_count, m_errcnt);
        check("xfer_count", xfer_count, m_xfer);
        check("burst_active", burst_active, m_in_burst);
        check("small_err_valid", s_err_valid, m_ev);
        check("small_err_count", s_err_count, sat3(m_errcnt));
        check("small_xfer_count", s_xfer_count, sat3(m_xfer));
    endtask

    task automatic step(input int t, input int a, input int w, input int s,
                        input int b, input int r);
        HTRANS = t[1:0]; HADDR = a[AW-1:0]; HWRITE = w[0];
        HSIZE = s[2:0]; HBURST = b[2:0]; HREADY = r[0];
        model_step(t, a, w, s, b, r);
        @(posedge HCLK); #1;
        compare_all();
    endtask

    task automatic do_reset();
        HRESETn = 1'b0;
        model_reset();
        @(posedge HCLK); #1;
        compare_all();
        HRESETn = 1'b1;
        HTRANS = 2'b00; HREADY = 1'b1;
    endtask

    initial begin
        // Reset state
        do_reset();
        check("reset_err_code", err_code, 3'd0);

        // INCR4 at 0x100, clean
        step(2, 'h100, 0, 0, 3, 1);
        step(3, 'h101, 0, 0, 3, 1);
        step(3, 'h102, 0, 0, 3, 1);
        check("incr4_active_mid", burst_active, 1'b1);
        step(3, 'h103, 0, 0, 3, 1);
        check("incr4_xfer", xfer_count, 16'd4);
        check("incr4_active_end", burst_active, 1'b0);
        check("incr4_no_err", err_count, 16'd0);
        step(0, 0, 0, 0, 0, 1);

        // WRAP4 at 0x00E, clean then bad second address
        step(2, 'h00E, 0, 0, 2, 1);
        step(3, 'h00F, 0, 0, 2, 1);
        step(3, 'h00C, 0, 0, 2, 1);
        step(3, 'h00D, 0, 0, 2, 1);
        check("wrap4_no_err", err_count, 16'd0);
        step(2, 'h00E, 0, 0, 2, 1);
        step(3, 'h010, 0, 0, 2, 1);
        check("wrap4_bad_code", err_code, 3'd3);
        check("wrap4_bad_addr", err_addr, 21'h010);
        step(0, 0, 0, 0, 0, 1);

        // SEQ out of reset, then BUSY in IDLE
        do_reset();
        step(3, 'h40, 0, 0, 1, 1);
        check("seq_idle_code", err_code, 3'd2);
        step(1, 'h40, 0, 0, 1, 1);
        check("busy_idle_code", err_code, 3'd1);
        check("busy_idle_valid", err_valid, 1'b1);
        check("two_errs", err_count, 16'd2);

        // Wait-state stability
        do_reset();
        step(2, 'h200, 0, 0, 0, 0);
        step(2, 'h204, 0, 0, 0, 1);
        check("wait_change_code", err_code, 3'd4);
        step(2, 'h300, 1, 0, 0, 0);
        step(2, 'h300, 1, 0, 0, 0);
        step(2, 'h300, 1, 0, 0, 0);
        step(2, 'h300, 1, 0, 0, 1);
        check("wait_hold_count", err_count, 16'd1);

        // BAD_SIZE together with EARLY_TERM, then INCR8 cut short
        do_reset();
        step(2, 'h40, 0, 0, 3, 1);
        step(3, 'h41, 0, 0, 3, 1);
        step(2, 'h80, 0, 1, 0, 1);
        check("size_code", err_code, 3'd5);
        check("size_count", err_count, 16'd1);
        step(2, 'h100, 0, 0, 5, 1);
        step(3, 'h101, 0, 0, 5, 1);
        step(3, 'h102, 0, 0, 5, 1);
        step(2, 'h180, 0, 0, 0, 1);
        check("early_term_code", err_code, 3'd6);
        step(0, 0, 0, 0, 0, 1);

        // Saturation on the 2-bit counters
        do_reset();
        for (int i = 0; i < 5; i++) step(3, 'h10 + i, 0, 0, 1, 1);
        check("sat_small", s_err_count, 2'd3);
        check("sat_big", err_count, 16'd5);

        // Reset in the middle of INCR16
        step(2, 'h400, 0, 0, 7, 1);
        step(3, 'h401, 0, 0, 7, 1);
        step(3, 'h402, 0, 0, 7, 1);
        do_reset();
        check("mid_reset_active", burst_active, 1'b0);
        check("mid_reset_valid", err_valid, 1'b0);
        step(3, 'h403, 0, 0, 7, 1);
        check("post_reset_seq", err_code, 3'd2);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 800; i++) begin
            int t, a, w, s, b, r;
            if (m_wait && $urandom_range(0, 9) < 7) begin
                t = HTRANS; a = HADDR; w = HWRITE; s = HSIZE; b = HBURST;
            end else if (m_in_burst && $urandom_range(0, 9) < 7) begin
                t = 3; a = m_exp; w = HWRITE; s = m_size; b = m_btype;
            end else begin
                t = $urandom_range(0, 3);
                a = $urandom_range(0, AMASK);
                w = $urandom_range(0, 1);
                s = ($urandom_range(0, 9) < 8) ? 0 : $urandom_range(0, 7);
                b = $urandom_range(0, 7);
            end
            if ($urandom_range(0, 19) == 0) a = a ^ 1;
            r = ($urandom_range(0, 9) < 8) ? 1 : 0;
            if ($urandom_range(0, 149) == 0) do_reset();
            else step(t, a, w, s, b, r);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ahb_lite_protocol_checker.md
# ahb_lite_protocol_checker

Parametrised, passive AHB-Lite address-phase protocol checker that sits on the bus interface alongside the master VIP and slave under test. Generalises the earlier negedge HTRANS check to full HTRANS/HBURST legality: it tracks burst state, expected SEQ addresses, wait-state stability and HSIZE range. Every violation is reported as a registered error pulse with a code and address, and violations and accepted transfers are counted.

## Interface
- ADDR_W, 21: HADDR width.
- DATA_W, 8: data bus width in bits; one of 8, 16, 32 or 64.
- CNT_W, 16: width of the error and transfer counters.
- HCLK  in  1  bus clock; all logic on posedge.
- HRESETn  in  1  reset, synchronous, active-low.
- HADDR  in  ADDR_W  address.
- HTRANS  in  2  transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- HWRITE  in  1  direction.
- HSIZE  in  3  transfer size, log2 of bytes.
- HBURST  in  3  burst type: 0 SINGLE, 1 INCR, 2 WRAP4, 3 INCR4, 4 WRAP8, 5 INCR8, 6 WRAP16, 7 INCR16.
- HREADY  in  1  transfer accepted / wait state.
- err_valid  out  1  one-cycle error pulse.
- err_code  out  3  code of the reported error.
- err_addr  out  ADDR_W  HADDR of the offending cycle.
- err_count  out  CNT_W  total errors, saturating.
- xfer_count  out  CNT_W  accepted NONSEQ/SEQ transfers, saturating.
- burst_active  out  1  FSM is in the BURST state.

## Operation
- Sample point: every posedge HCLK with HRESETn=1. A cycle is "accepted" when HREADY=1.
- FSM has two states, IDLE and BURST.
  - IDLE to BURST: accepted NONSEQ with HBURST≠SINGLE. Capture HBURST and HSIZE; set beats_left to 3/7/15 for 4/8/16-beat bursts, unbounded for INCR.
  - BURST stays in BURST: accepted SEQ decrements beats_left; BUSY holds all state.
  - BURST to IDLE: beats_left reaches 0, or an accepted IDLE occurs.
  - Accepted NONSEQ in BURST restarts capture.
- Expected next address on each accepted NONSEQ/SEQ, with bytes=1<<HSIZE:
  - INCR types: addr+bytes.
  - WRAPn: bound=n·bytes; next=(addr & ~(bound-1)) | ((addr+bytes) & (bound-1)).
- Error codes, checked on accepted cycles unless stated otherwise:
  - 1 BUSY_NO_BURST: BUSY while in IDLE.
  - 2 SEQ_NO_BURST: SEQ while in IDLE.
  - 3 SEQ_ADDR: SEQ with HADDR≠expected, or HSIZE/HBURST differing from the captured values.
  - 4 WAIT_UNSTABLE: checked on any cycle following a cycle with HREADY=0 and HTRANS∈{NONSEQ,SEQ}. Fires if HADDR, HTRANS, HWRITE, HSIZE or HBURST changed. The one exception is IDLE→NONSEQ.
  - 5 BAD_SIZE: NONSEQ/SEQ with HSIZE > log2(DATA_W/8).
  - 6 EARLY_TERM: NONSEQ or IDLE while a fixed-length burst has beats_left>0.
- Several errors in one cycle: the lowest code is reported, and err_count increments by 1.
- After an error, the FSM still follows the transition rules above. On SEQ_NO_BURST it remains in IDLE.

## Timing
- err_valid, err_code, err_addr and the counters are registered and update one cycle after the sampled edge.
- err_valid is high for exactly one cycle per offending cycle. Back-to-back errors give back-to-back pulses.
- err_code and err_addr hold their last values until the next error.
- burst_active reflects the FSM with no added latency.
- Reset (HRESETn=0 at posedge): all outputs, counters, beats_left and captured controls go to 0; FSM goes to IDLE.
  - Reset mid-burst abandons the burst with no error.
  - The first SEQ after release gives code 2.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Address arithmetic is modulo 2^ADDR_W.

## Configuration
- AHB_CHK_ASSERT_EN defined: each error also issues $error with the code name, HADDR and HTRANS in the same cycle as err_valid. This is simulation only.
- AHB_CHK_ASSERT_EN undefined: no messages; only the output ports report errors. Logic is otherwise identical.

## Test plan
- INCR4 NONSEQ at 0x100, HSIZE=0, then SEQ 0x101/0x102/0x103 with HREADY=1: no err_valid; xfer_count=4; burst_active drops after the last beat.
- WRAP4 NONSEQ at 0x00E, HSIZE=0, then SEQ 0x00F, 0x00C, 0x00D: no error. Repeat with 0x010 as the second address: err_code=3, err_addr=0x010.
- SEQ straight out of reset, then BUSY in IDLE: two consecutive pulses, codes 2 then 1; err_count=2.
- NONSEQ at 0x200 with HREADY=0, next cycle HADDR=0x204: err_code=4. Same HADDR held for 3 wait cycles: no error.
- DATA_W=8 with NONSEQ HSIZE=1 in the same cycle as an EARLY_TERM condition: only code 5 reported, err_count +1. INCR8 cut by NONSEQ after 3 beats: code 6.
- CNT_W=2 with 5 errors: err_count saturates at 3. Pulse HRESETn low mid-INCR16: all outputs 0, no error.
